// File: rtl/bus_source_arbiter_pkg.sv
// Shared definitions for the bus source arbiter: sizes, FSM states, index helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arb_pkg;

  localparam int N_SRC  = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANTED
  } arb_state_t;

  // Turn a mux select index into the matching one-hot grant vector.
  function automatic logic [N_SRC-1:0] sel2onehot(input logic [SEL_W-1:0] s);
    return N_SRC'(1) << s;
  endfunction

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Request/grant bundle between the control unit, the arbiter and the bus mux.
// Latency: n/a (wires only).
// Backpressure: none; REQ is level-sensitive and held by the requester until served.
//
// Signals:
//   REQ       per-source bus request, driven by the requesters (master side)
//   GNT       one-hot grant, all-zero when idle
//   SEL       {S2,S1,S0} for the 8:1 bus mux
//   BUS_VALID high whenever GNT is non-zero
//   HOLD_CNT  cycles the current grantee has held the bus
interface bus_source_arbiter_if;
  import bus_arb_pkg::*;

  logic [N_SRC-1:0]  REQ;
  logic [N_SRC-1:0]  GNT;
  logic [SEL_W-1:0]  SEL;
  logic              BUS_VALID;
  logic [HOLD_W-1:0] HOLD_CNT;

  modport master (
    output REQ,
    input  GNT, SEL, BUS_VALID, HOLD_CNT
  );

  modport slave (
    input  REQ,
    output GNT, SEL, BUS_VALID, HOLD_CNT
  );

endinterface

// File: rtl/bus_source_arbiter_rr_pick.sv
// Round-robin search: first set request bit strictly after ptr, wrapping back to ptr itself last.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports:
//   req   [7:0] candidate requests
//   ptr   [2:0] last granted index (lowest priority)
//   found       any req bit set
//   idx   [2:0] winning index (0 when nothing found)
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Offsets 1..8; offset 8 wraps modulo 8 onto ptr so the last grantee is tried last.
    for (int k = 1; k <= N_SRC; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the 8:1 internal bus mux select with bounded hold (MAX_HOLD) under contention.
// Latency: REQ sampled at a rising edge is reflected in GNT/SEL right after that edge; zero-bubble handover.
// Backpressure: none; requesters hold REQ until granted, a lone requester may keep the bus indefinitely.
//
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    slave side of bus_source_arbiter_if (REQ in; GNT, SEL, BUS_VALID, HOLD_CNT out, all registered)
module bus_source_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4   // 1..15
)(
  input  logic                  CLK,
  input  logic                  RST_N,
  bus_source_arbiter_if.slave   bus
);

  localparam logic [HOLD_W-1:0] MAX_H = HOLD_W'(MAX_HOLD);

  arb_state_t        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q,   ptr_d;
  logic [N_SRC-1:0]  gnt_q,   gnt_d;
  logic [SEL_W-1:0]  sel_q,   sel_d;
  logic              valid_q, valid_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;

  logic [N_SRC-1:0]  req_m;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;
  logic              take;

  // Exclude the current grantee from the search; in IDLE gnt_q is zero so every
  // requester competes, with the last grantee searched last.
  assign req_m = bus.REQ & ~gnt_q;

  rr_pick u_pick (
    .req   (req_m),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    hold_d  = hold_q;
    take    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) take = 1'b1;
      end
      ARB_GRANTED: begin
        // ptr_q always equals the grantee's index while GRANTED.
        if (!bus.REQ[ptr_q]) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            // SEL deliberately left alone so the mux output stays stable while idle.
            state_d = ARB_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (hold_q < MAX_H) begin
          hold_d = hold_q + 1'b1;
        end else if (pick_found) begin
          take = 1'b1;
        end
        // Otherwise: expired but uncontested, keep the bus with HOLD_CNT pinned at MAX_HOLD.
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase

    if (take) begin
      state_d = ARB_GRANTED;
      ptr_d   = pick_idx;
      gnt_d   = sel2onehot(pick_idx);
      sel_d   = pick_idx;
      valid_d = 1'b1;
      hold_d  = HOLD_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ARB_IDLE;
      ptr_q   <= SEL_W'(N_SRC - 1);   // index 0 gets first priority out of reset
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.SEL       = sel_q;
  assign bus.BUS_VALID = valid_q;
  assign bus.HOLD_CNT  = hold_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
module tb_bus_source_arbiter;

  localparam int MH = 4;

  logic CLK;
  logic RST_N;

  bus_source_arbiter_if bus_if ();

  bus_source_arbiter #(.MAX_HOLD(MH)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_pass;

  // Reference model: owner index (-1 = idle), last-granted pointer, hold count, select.
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_sel;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       vld;
    logic [3:0] hold;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endtask

  task automatic chk_out(input string nm, input int gnt, input int sel, input int vld, input int hold);
    chk({nm, ".gnt"},  int'(bus_if.GNT),       gnt);
    chk({nm, ".sel"},  int'(bus_if.SEL),       sel);
    chk({nm, ".vld"},  int'(bus_if.BUS_VALID), vld);
    chk({nm, ".hold"}, int'(bus_if.HOLD_CNT),  hold);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 7;
    m_hold  = 0;
    m_sel   = 0;
  endtask

  // One edge of the arbitration rules, expressed on plain integers.
  task automatic model_step(input logic [7:0] r);
    int nxt;
    nxt = -1;
    for (int k = 1; k <= 8; k++) begin
      if (nxt < 0 && r[(m_ptr + k) % 8] && ((m_ptr + k) % 8) != m_owner) nxt = (m_ptr + k) % 8;
    end
    if (m_owner < 0 || !r[m_owner] || m_hold >= MH) begin
      if (nxt >= 0) begin
        m_owner = nxt;
        m_ptr   = nxt;
        m_sel   = nxt;
        m_hold  = 1;
      end else if (m_owner >= 0 && !r[m_owner]) begin
        m_owner = -1;
        m_hold  = 0;
      end
    end else begin
      m_hold++;
    end
  endtask

  task automatic chk_model(input string nm);
    chk_out(nm, (m_owner < 0) ? 0 : (1 << m_owner), m_sel, (m_owner >= 0) ? 1 : 0, m_hold);
  endtask

  // Apply REQ, let one rising edge pass, advance the model, then sample 1 time unit later.
  task automatic tick(input logic [7:0] r);
    bus_if.REQ = r;
    @(posedge CLK);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    bus_if.REQ = '0;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    bus_if.REQ = '0;
    RST_N = 1'b1;
    model_reset();

    // Idle, single requester 4, then release and the 8'h04 -> 8'h21 -> 8'h01 search-order case.
    repeat (5) tbl.push_back('{req: 8'h00, gnt: 8'h00, sel: 3'd0, vld: 1'b0, hold: 4'd0});
    tbl.push_back('{req: 8'h10, gnt: 8'h10, sel: 3'd4, vld: 1'b1, hold: 4'd1});
    tbl.push_back('{req: 8'h10, gnt: 8'h10, sel: 3'd4, vld: 1'b1, hold: 4'd2});
    tbl.push_back('{req: 8'h10, gnt: 8'h10, sel: 3'd4, vld: 1'b1, hold: 4'd3});
    tbl.push_back('{req: 8'h00, gnt: 8'h00, sel: 3'd4, vld: 1'b0, hold: 4'd0});
    tbl.push_back('{req: 8'h00, gnt: 8'h00, sel: 3'd4, vld: 1'b0, hold: 4'd0});
    tbl.push_back('{req: 8'h04, gnt: 8'h04, sel: 3'd2, vld: 1'b1, hold: 4'd1});
    tbl.push_back('{req: 8'h21, gnt: 8'h20, sel: 3'd5, vld: 1'b1, hold: 4'd1});
    tbl.push_back('{req: 8'h01, gnt: 8'h01, sel: 3'd0, vld: 1'b1, hold: 4'd1});
    tbl.push_back('{req: 8'h00, gnt: 8'h00, sel: 3'd0, vld: 1'b0, hold: 4'd0});

    do_reset();
    chk_out("reset", 0, 0, 0, 0);

    foreach (tbl[i]) begin
      tick(tbl[i].req);
      chk_out($sformatf("vec%0d", i), int'(tbl[i].gnt), int'(tbl[i].sel), int'(tbl[i].vld), int'(tbl[i].hold));
    end

    // Lone requester 3 for 20 cycles: grant never moves, HOLD_CNT saturates.
    for (int t = 1; t <= 20; t++) begin
      tick(8'h08);
      chk_out($sformatf("solo3_c%0d", t), 8'h08, 3, 1, (t < MH) ? t : MH);
    end

    // Asynchronous reset in the middle of the clock period clears outputs without an edge.
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0);
    @(posedge CLK);
    #2;
    RST_N = 1'b1;
    model_reset();

    tick(8'h81);
    chk_out("post_rst_81", 8'h01, 0, 1, 1);

    // All sources requesting: 0..7 then back to 0, MAX_HOLD cycles each, no idle gap.
    for (int t = 1; t < 8 * MH + 4; t++) begin
      tick(8'hFF);
      chk_out($sformatf("rot_c%0d", t), 1 << ((t / MH) % 8), (t / MH) % 8, 1, (t % MH) + 1);
    end

    // Randomized traffic against the reference model; sparse bits so releases happen often.
    do_reset();
    chk_model("rnd_reset");
    for (int t = 0; t < 400; t++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom) & ((t % 50 < 25) ? 8'hFF : 8'($urandom));
      if (t % 37 == 0) r = 8'h00;
      tick(r);
      chk_model($sformatf("rnd_c%0d", t));
      if (t == 200) begin
        do_reset();
        chk_model("rnd_mid_reset");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
